sevenseg_reader: RTL and testbench

Sequential decoder for the 8-digit seven-segment bus. It watches the `HEX7..HEX0` segment lines and waits for the pattern to hold steady. It then converts the four numeric digits (`HEX3..HEX0`) back to a binary value and pulses `valid`. It sits on the far side of the display driver, in the SNR self-check/loopback path and in benches, so the displayed SNR can be read back and compared against the source value.

---
 rtl/sevenseg_pkg.sv | 30 +++
 rtl/sevenseg_digit_decode.sv | 36 +++
 rtl/sevenseg_reader.sv | 164 ++++++++++++++++
 tb/tb_sevenseg_reader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared segment codes and FSM state type for the seven-segment read-back path.
// All codes are active-low, bit 6..0 = g..a.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  localparam logic [6:0] SEG_S = 7'b001_0010;
  localparam logic [6:0] SEG_R = 7'b010_1111;
  localparam logic [6:0] SEG_D = 7'b010_0001;
  localparam logic [6:0] SEG_B = 7'b000_0011;

  localparam logic [27:0] LABEL_SRDB = {SEG_S, SEG_R, SEG_D, SEG_B};

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_CONVERT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sevenseg_digit_decode.sv
// Combinational map from one active-low segment code to a BCD digit.
// Blank and unrecognised codes both return digit 0; the flags tell them apart.
module sevenseg_digit_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       is_blank_o,
  output logic       is_digit_o
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    digit_o    = 4'd0;
    is_blank_o = 1'b0;
    is_digit_o = 1'b1;
    case (seg_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_BLANK: begin
        is_blank_o = 1'b1;
        is_digit_o = 1'b0;
      end
      default:   is_digit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Reads an 8-digit seven-segment bus back to binary once the pattern holds steady,
// so a displayed value can be compared against its source.
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int ACTIVE_LOW    = 1,
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  HEX0,
  input  logic [6:0]  HEX1,
  input  logic [6:0]  HEX2,
  input  logic [6:0]  HEX3,
  input  logic [6:0]  HEX4,
  input  logic [6:0]  HEX5,
  input  logic [6:0]  HEX6,
  input  logic [6:0]  HEX7,
  output logic [15:0] value,
  output logic        valid,
  output logic        err,
  output logic        label_ok,
  output logic        busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [55:0] seg_raw, seg_in;
  assign seg_raw = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  assign seg_in  = (ACTIVE_LOW != 0) ? seg_raw : ~seg_raw;

  state_e        state_q, state_d;
  logic [55:0]   snap_q, work_q, work_d, last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          have_last_q, have_last_d;
  logic [13:0]   acc_q, acc_d;
  logic [1:0]    step_q, step_d;
  logic          err_flag_q, err_flag_d, seen_q, seen_d;
  logic [15:0]   value_q, value_d;
  logic          valid_q, valid_d, err_q, err_d, label_q, label_d;

  // Step 0 is the thousands digit (HEX3), step 3 the ones digit (HEX0).
  logic [6:0] cur_seg;
  logic [3:0] cur_digit;
  logic       cur_blank, cur_is_digit;

  always_comb begin
    cur_seg = work_q[6:0];
    case (step_q)
      2'd0: cur_seg = work_q[27:21];
      2'd1: cur_seg = work_q[20:14];
      2'd2: cur_seg = work_q[13:7];
      2'd3: cur_seg = work_q[6:0];
      default: cur_seg = work_q[6:0];
    endcase
  end

  sevenseg_digit_decode u_digit (
    .seg_i      (cur_seg),
    .digit_o    (cur_digit),
    .is_blank_o (cur_blank),
    .is_digit_o (cur_is_digit)
  );

  always_comb begin
    if (seg_in != snap_q)      cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    acc_d       = acc_q;
    step_d      = step_q;
    err_flag_d  = err_flag_q;
    seen_d      = seen_q;
    value_d     = value_q;
    valid_d     = 1'b0;
    err_d       = err_q;
    label_d     = label_q;
    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == CNT_MAX && (!have_last_q || snap_q != last_q)) begin
          state_d     = ST_CONVERT;
          work_d      = snap_q;
          last_d      = snap_q;
          have_last_d = 1'b1;
          acc_d       = '0;
          step_d      = '0;
          err_flag_d  = 1'b0;
          seen_d      = 1'b0;
        end
      end
      ST_CONVERT: begin
        acc_d  = acc_q * 14'd10 + {10'd0, cur_digit};
        step_d = step_q + 2'd1;
        // Leading blanks read as zero; a blank after a digit or in the ones place is malformed.
        if (cur_blank) begin
          if (seen_q || step_q == 2'd3) err_flag_d = 1'b1;
        end else if (cur_is_digit) begin
          seen_d = 1'b1;
        end else begin
          err_flag_d = 1'b1;
        end
        if (step_q == 2'd3) state_d = ST_DONE;
      end
      ST_DONE: begin
        valid_d = 1'b1;
        err_d   = err_flag_q;
        label_d = (work_q[55:28] == LABEL_SRDB);
        if (!err_flag_q) value_d = {2'b00, acc_q};
        state_d = ST_SETTLE;
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= '0;
      have_last_q <= 1'b0;
      acc_q       <= '0;
      step_q      <= '0;
      err_flag_q  <= 1'b0;
      seen_q      <= 1'b0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      label_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      have_last_q <= have_last_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      err_flag_q  <= err_flag_d;
      seen_q      <= seen_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      label_q     <= label_d;
    end
  end

  // NOTE: wide pattern registers carry no reset; have_last and cnt gate every use of them.
  always_ff @(posedge clk) begin
    snap_q <= seg_in;
    work_q <= work_d;
    last_q <= last_d;
  end

  assign value    = value_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign label_ok = label_q;
  assign busy     = (state_q != ST_SETTLE);

endmodule

// File: tb/tb_sevenseg_reader.sv
// Directed bench for sevenseg_reader: one active-low and one active-high instance,
// both with a 4-cycle stability window.
module tb_sevenseg_reader;

  localparam int SC = 4;

  localparam logic [6:0] C0 = 7'h40, C1 = 7'h79, C2 = 7'h24, C3 = 7'h30, C4 = 7'h19;
  localparam logic [6:0] C5 = 7'h12, C7 = 7'h78, C9 = 7'h10, BL = 7'h7F;
  localparam logic [27:0] LABEL = {7'h12, 7'h2F, 7'h21, 7'h03};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [55:0] hex_a = {8{BL}};
  logic [55:0] hex_b = 56'd0;

  logic [15:0] value_a, value_b;
  logic        valid_a, err_a, label_a, busy_a;
  logic        valid_b, err_b, label_b, busy_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sevenseg_reader #(.ACTIVE_LOW(1), .STABLE_CYCLES(SC)) dut_a (
    .clk(clk), .reset(reset),
    .HEX0(hex_a[6:0]),   .HEX1(hex_a[13:7]),  .HEX2(hex_a[20:14]), .HEX3(hex_a[27:21]),
    .HEX4(hex_a[34:28]), .HEX5(hex_a[41:35]), .HEX6(hex_a[48:42]), .HEX7(hex_a[55:49]),
    .value(value_a), .valid(valid_a), .err(err_a), .label_ok(label_a), .busy(busy_a)
  );

  sevenseg_reader #(.ACTIVE_LOW(0), .STABLE_CYCLES(SC)) dut_b (
    .clk(clk), .reset(reset),
    .HEX0(hex_b[6:0]),   .HEX1(hex_b[13:7]),  .HEX2(hex_b[20:14]), .HEX3(hex_b[27:21]),
    .HEX4(hex_b[34:28]), .HEX5(hex_b[41:35]), .HEX6(hex_b[48:42]), .HEX7(hex_b[55:49]),
    .value(value_b), .valid(valid_b), .err(err_b), .label_ok(label_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until valid is seen (first edge = 1), or -1 on timeout.
  task automatic wait_valid(input bit sel_b, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((sel_b ? valid_b : valid_a) === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    logic [15:0] cap;
    bit seen_busy;

    // Reset state
    repeat (3) tick();
    check("rst_value", value_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_err",   err_a,   0);
    check("rst_label", label_a, 0);
    check("rst_busy",  busy_a,  0);
    reset = 1'b0;

    // 1: basic decode; edge 0 samples the pattern, valid follows edge SC+6 -> seen at edge SC+7
    hex_a = {LABEL, BL, BL, C4, C2};
    wait_valid(1'b0, 40, n);
    check("t1_latency", n, SC + 7);
    check("t1_value", value_a, 42);
    check("t1_err",   err_a,   0);
    check("t1_label", label_a, 1);
    tick();
    check("t1_pulse_width", valid_a, 0);

    // 2: no repeat of a held pattern, then a new one
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (valid_a) pulses++;
    end
    check("t2_no_repeat", pulses, 0);
    hex_a = {LABEL, C1, C2, C3, C4};
    wait_valid(1'b0, 40, n);
    check("t2_latency", n, SC + 7);
    check("t2_value", value_a, 1234);
    check("t2_err",   err_a,   0);

    // 3: glitch rejection
    pulses = 0;
    cap = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      hex_a = {LABEL, C0, C0, (i % 2 == 0) ? C3 : C7, C9};
      repeat (2) begin
        tick();
        if (valid_a) pulses++;
      end
    end
    hex_a = {LABEL, C0, C0, C9, C9};
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid_a) begin
        pulses++;
        cap = value_a;
      end
    end
    check("t3_pulses", pulses, 1);
    check("t3_value", cap, 99);

    // 4: malformed digits keep the last good value (99)
    hex_a = {LABEL, BL, 7'b101_0101, C4, C2};
    wait_valid(1'b0, 40, n);
    check("t4a_valid", n, SC + 7);
    check("t4a_err",   err_a,   1);
    check("t4a_value", value_a, 99);
    check("t4a_label", label_a, 1);
    hex_a = {LABEL, C1, BL, C0, C5};
    wait_valid(1'b0, 40, n);
    check("t4b_valid", n, SC + 7);
    check("t4b_err",   err_a,   1);
    check("t4b_value", value_a, 99);
    hex_a = {LABEL, C0, C0, C1, BL};
    wait_valid(1'b0, 40, n);
    check("t4c_valid", n, SC + 7);
    check("t4c_err",   err_a,   1);

    // 5: reset while converting, then the held pattern is decoded again
    hex_a = {LABEL, BL, BL, C4, C2};
    seen_busy = 1'b0;
    for (int i = 0; i < 40 && !seen_busy; i++) begin
      tick();
      if (busy_a) seen_busy = 1'b1;
    end
    check("t5_reached_convert", seen_busy, 1);
    reset = 1'b1;
    tick();
    check("t5_rst_value", value_a, 0);
    check("t5_rst_valid", valid_a, 0);
    check("t5_rst_err",   err_a,   0);
    check("t5_rst_label", label_a, 0);
    check("t5_rst_busy",  busy_a,  0);
    reset = 1'b0;
    wait_valid(1'b0, 40, n);
    check("t5_latency", n, SC + 6);
    check("t5_value", value_a, 42);
    check("t5_err",   err_a,   0);

    // 6: active-high polarity instance, then a blank label
    hex_b = ~{LABEL, C9, C9, C9, C9};
    wait_valid(1'b1, 40, n);
    check("t6_latency", n, SC + 7);
    check("t6_value", value_b, 9999);
    check("t6_err",   err_b,   0);
    check("t6_label", label_b, 1);
    hex_b = {28'd0, ~{C9, C9, C9, C9}};
    wait_valid(1'b1, 40, n);
    check("t6b_valid", n, SC + 7);
    check("t6b_label", label_b, 0);
    check("t6b_err",   err_b,   0);
    check("t6b_value", value_b, 9999);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
